ps2_transmitter: RTL and testbench

PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_line_sync.sv | 43 ++++
 rtl/ps2_transmitter.sv | 198 +++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks: the host-to-device
// transmitter state encoding, default line timings for a 100 MHz system
// clock, the keyboard command bytes the host sends most often, and the
// odd-parity helper used when framing a byte.
// ----------------------------------------------------------------------------
package ps2_pkg;

  // Host-to-device transfer sequence:
  // IDLE      - waiting for a byte
  // INHIBIT   - holding the clock line low to claim the bus
  // RTS       - request-to-send: start bit on data, clock about to be released
  // SEND      - device clocks out data bits, parity and stop
  // ACK       - waiting for the device acknowledge clock
  // WAIT_IDLE - waiting for the device to release both lines
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } tx_state_e;

  // 120 us of clock inhibit at 100 MHz.
  localparam int PS2_INHIBIT_CYCLES_DEFAULT = 12000;
  // 15 ms upper bound from clock release to end of transfer at 100 MHz.
  localparam int PS2_TIMEOUT_CYCLES_DEFAULT = 1500000;

  // Number of device falling edges that shift out data, parity and stop.
  localparam int PS2_FRAME_SEND_EDGES = 10;

  // Keyboard command bytes.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESEND   = 8'hFE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // PS/2 uses odd parity: the parity bit makes the total count of ones
  // across data plus parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ----------------------------------------------------------------------------
// ps2_line_sync
// Brings one asynchronous PS/2 pad line into the clk domain and flags its
// falling edges. Shared by the transmitter and the receiver path.
//
// Ports
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset; flops preset to 1 (idle line)
//   line   in  raw pad level (asynchronous)
//   level  out synchronized line level (second synchronizer flop)
//   fall   out one-cycle pulse, the cycle after level went 1 -> 0
// ----------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta;
  logic stable;
  logic stable_d;

  // Two-flop synchronizer plus a history flop for edge detection. Presetting
  // to 1 matches an idle PS/2 line, so leaving reset never fakes an edge
  // unless the line really is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta     <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
    end else begin
      meta     <= line;
      stable   <= meta;
      stable_d <= stable;
    end
  end

  assign level = stable;
  assign fall  = stable_d & ~stable;

endmodule

// File: rtl/ps2_transmitter.sv
// ----------------------------------------------------------------------------
// ps2_transmitter
// Host-to-device PS/2 byte transmitter. Claims the bus by inhibiting the
// clock, issues request-to-send, then lets the device clock out the start
// bit, 8 data bits (LSB first), odd parity and stop bit, and finally checks
// the device acknowledge. The pad lines are open-drain; this block only
// decides when to pull them low.
//
// Parameters
//   INHIBIT_CYCLES  clk cycles the clock line is held low before RTS (>= 2)
//   TIMEOUT_CYCLES  clk cycles allowed from clock release to completion
//
// Ports
//   clk                in  system clock, rising edge
//   reset              in  asynchronous active-high reset
//   PS2Clk             in  PS/2 clock pad level (asynchronous)
//   PS2Data            in  PS/2 data pad level (asynchronous)
//   ps2clk_drive_low   out 1 = pull PS2Clk low
//   ps2data_drive_low  out 1 = pull PS2Data low
//   tx_data            in  command byte to send
//   tx_valid           in  tx_data valid
//   tx_ready           out byte accepted this cycle when tx_valid is high
//   tx_done            out pulse: byte sent and acknowledged
//   tx_ack_err         out pulse: device did not acknowledge
//   tx_timeout         out pulse: transfer abandoned after TIMEOUT_CYCLES
//   busy               out transfer in progress (receiver ignores frames)
// ----------------------------------------------------------------------------
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       ps2clk_drive_low,
  output logic       ps2data_drive_low,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout,
  output logic       busy
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_level;
  logic          clk_fall;
  logic          data_level;
  logic          data_fall_unused;

  tx_state_e     state;
  logic [8:0]    shift;
  logic [3:0]    edge_cnt;
  logic          ack_ok;
  logic [IW-1:0] inhibit_cnt;
  logic [TW-1:0] timeout_cnt;
  logic          timed_out;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .line  (PS2Clk),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk   (clk),
    .reset (reset),
    .line  (PS2Data),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  assign timed_out = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Transfer sequencer. All line drives and status outputs are registered so
  // the open-drain enables never glitch.
  //
  // Clock-inhibit length: the clock drive rises on the accept edge and spans
  // the INHIBIT cycles plus the single RTS cycle, so INHIBIT lasts
  // INHIBIT_CYCLES-1 cycles. The start bit goes out on the last inhibit cycle,
  // before the clock is let go.
  //
  // Framing: shift holds {parity, data}; each device falling edge drives the
  // inverted LSB and shifts in a 1, so the tenth edge releases data for the
  // stop bit without a separate branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      ps2clk_drive_low  <= 1'b0;
      ps2data_drive_low <= 1'b0;
      tx_ready          <= 1'b1;
      busy              <= 1'b0;
      tx_done           <= 1'b0;
      tx_ack_err        <= 1'b0;
      tx_timeout        <= 1'b0;
      shift             <= '0;
      edge_cnt          <= '0;
      ack_ok            <= 1'b0;
      inhibit_cnt       <= '0;
      timeout_cnt       <= '0;
    end else begin
      tx_done    <= 1'b0;
      tx_ack_err <= 1'b0;
      tx_timeout <= 1'b0;

      if ((state inside {SEND, ACK, WAIT_IDLE}) && timed_out) begin
        state             <= IDLE;
        ps2clk_drive_low  <= 1'b0;
        ps2data_drive_low <= 1'b0;
        tx_ready          <= 1'b1;
        busy              <= 1'b0;
        tx_timeout        <= 1'b1;
        timeout_cnt       <= '0;
      end else begin
        if (state inside {SEND, ACK, WAIT_IDLE}) begin
          timeout_cnt <= timeout_cnt + TW'(1);
        end

        case (state)
          IDLE: begin
            tx_ready          <= 1'b1;
            busy              <= 1'b0;
            ps2clk_drive_low  <= 1'b0;
            ps2data_drive_low <= 1'b0;
            if (tx_valid && tx_ready) begin
              shift            <= {odd_parity(tx_data), tx_data};
              tx_ready         <= 1'b0;
              busy             <= 1'b1;
              ps2clk_drive_low <= 1'b1;
              inhibit_cnt      <= '0;
              state            <= INHIBIT;
            end
          end

          INHIBIT: begin
            inhibit_cnt <= inhibit_cnt + IW'(1);
            if (inhibit_cnt == IW'(INHIBIT_CYCLES - 2)) begin
              ps2data_drive_low <= 1'b1;
              state             <= RTS;
            end
          end

          RTS: begin
            ps2clk_drive_low <= 1'b0;
            timeout_cnt      <= '0;
            edge_cnt         <= '0;
            state            <= SEND;
          end

          SEND: begin
            if (clk_fall) begin
              ps2data_drive_low <= ~shift[0];
              shift             <= {1'b1, shift[8:1]};
              edge_cnt          <= edge_cnt + 4'd1;
              if (edge_cnt == 4'(PS2_FRAME_SEND_EDGES - 1)) begin
                state <= ACK;
              end
            end
          end

          ACK: begin
            if (clk_fall) begin
              ack_ok <= ~data_level;
              state  <= WAIT_IDLE;
            end
          end

          WAIT_IDLE: begin
            if (clk_level && data_level) begin
              tx_done    <= ack_ok;
              tx_ack_err <= ~ack_ok;
              tx_ready   <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end

          default: begin
            state             <= IDLE;
            ps2clk_drive_low  <= 1'b0;
            ps2data_drive_low <= 1'b0;
            tx_ready          <= 1'b1;
            busy              <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
// ----------------------------------------------------------------------------
// tb_ps2_transmitter
// Drives ps2_transmitter against a keyboard model that clocks at a 40-cycle
// period. Expected completion results and expected frames are queued when a
// byte is issued; a pulse monitor and the keyboard model pop and compare.
// ----------------------------------------------------------------------------
module tb_ps2_transmitter;
  import ps2_pkg::*;

  localparam int INHIBIT  = 20;
  localparam int TIMEOUT  = 2000;
  localparam int HALF_BIT = 20;

  localparam logic [2:0] RES_DONE    = 3'b001;
  localparam logic [2:0] RES_ACKERR  = 3'b010;
  localparam logic [2:0] RES_TIMEOUT = 3'b100;

  logic       clk;
  logic       reset;
  logic       PS2Clk;
  logic       PS2Data;
  logic       ps2clk_drive_low;
  logic       ps2data_drive_low;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;
  logic       busy;

  logic       bfm_clk_low;
  logic       bfm_data_low;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int pulse_count = 0;
  int last_pulse_cyc = 0;

  int   bfm_edges = 0;
  logic bfm_ack = 1'b1;
  int   bfm_falls = 0;
  bit   bfm_active = 0;

  logic [2:0]  exp_result_q[$];
  logic [10:0] exp_frame_q[$];

  // Open-drain wired-AND of host and keyboard.
  assign PS2Clk  = ~(ps2clk_drive_low | bfm_clk_low);
  assign PS2Data = ~(ps2data_drive_low | bfm_data_low);

  ps2_transmitter #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .PS2Clk            (PS2Clk),
    .PS2Data           (PS2Data),
    .ps2clk_drive_low  (ps2clk_drive_low),
    .ps2data_drive_low (ps2data_drive_low),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_done           (tx_done),
    .tx_ack_err        (tx_ack_err),
    .tx_timeout        (tx_timeout),
    .busy              (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Completion pulse monitor: every pulse must match the oldest expected result.
  initial forever begin
    @(negedge clk);
    if (reset !== 1'b1 && (tx_done | tx_ack_err | tx_timeout) === 1'b1) begin
      pulse_count++;
      last_pulse_cyc = cyc;
      if (exp_result_q.size() == 0)
        checkOutput("unexpected_pulse", 32'({tx_timeout, tx_ack_err, tx_done}), 32'd0);
      else
        checkOutput("result_pulse", 32'({tx_timeout, tx_ack_err, tx_done}),
                    32'(exp_result_q.pop_front()));
    end
  end

  // Keyboard model: waits for request-to-send, then clocks bfm_edges falling
  // edges, sampling data on each rising edge. Drives ack after the stop bit.
  initial begin
    logic [10:0] frame;
    bfm_clk_low  = 1'b0;
    bfm_data_low = 1'b0;
    forever begin
      while (PS2Clk !== 1'b0) @(posedge clk);
      while (PS2Clk !== 1'b1) @(posedge clk);
      if (PS2Data === 1'b0 && bfm_edges > 0) begin
        bfm_active = 1;
        bfm_falls  = 0;
        frame      = '0;
        frame[0]   = PS2Data;
        repeat (HALF_BIT) @(posedge clk);
        for (int i = 1; i <= bfm_edges; i++) begin
          bfm_clk_low = 1'b1;
          bfm_falls   = i;
          repeat (HALF_BIT) @(posedge clk);
          bfm_clk_low = 1'b0;
          if (i <= 10) frame[i] = PS2Data;
          if (i == 10 && bfm_ack) bfm_data_low = 1'b1;
          repeat (HALF_BIT) @(posedge clk);
        end
        bfm_data_low = 1'b0;
        if (bfm_edges == 11) begin
          if (exp_frame_q.size() == 0)
            checkOutput("unexpected_frame", 32'(frame), 32'd0);
          else
            checkOutput("frame_bits", 32'(frame), 32'(exp_frame_q.pop_front()));
        end
        bfm_active = 0;
      end
    end
  end

  // Issue one byte and follow it to completion. parity is the hand-computed
  // odd-parity bit; edges is how many clocks the keyboard gives (11 full,
  // 0 none); hold_valid keeps tx_valid high with other data while busy.
  task automatic applyStimulus(input logic [7:0] data, input logic parity,
                               input int edges, input logic ack,
                               input logic [2:0] expected, input bit hold_valid);
    int n;
    int release_cyc;
    int start_pulses;
    int ready_leaks;
    bit got;
    bfm_edges = edges;
    bfm_ack   = ack;
    if (edges == 11) exp_frame_q.push_back({1'b1, parity, data, 1'b0});
    exp_result_q.push_back(expected);

    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_send", 32'(tx_ready), 32'd1);

    start_pulses = pulse_count;
    tx_data  = data;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold_valid) tx_data = data ^ 8'h5A;
    else tx_valid = 1'b0;

    n = 0;
    @(negedge clk);
    while (ps2clk_drive_low === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("inhibit_len", n, INHIBIT);
    checkOutput("start_bit_drive", 32'(ps2data_drive_low), 32'd1);
    release_cyc = cyc;

    got = 0;
    ready_leaks = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      #1;
      if (pulse_count != start_pulses) got = 1;
      else if (tx_ready === 1'b1) ready_leaks++;
    end
    tx_valid = 1'b0;
    checkOutput("completion_seen", 32'(got), 32'd1);
    checkOutput("ready_low_while_busy", ready_leaks, 0);

    if (expected == RES_TIMEOUT) begin
      checkOutput("timeout_latency", last_pulse_cyc - release_cyc, TIMEOUT);
      checkOutput("lines_released", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'd0);
      checkOutput("ready_after_timeout", 32'(tx_ready), 32'd1);
    end

    n = 0;
    while (bfm_active && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int n;
    int pulses_before;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_drives", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'd0);
    checkOutput("reset_pulses", 32'({tx_timeout, tx_ack_err, tx_done}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0xED: six ones -> parity 1
    applyStimulus(CMD_SET_LEDS, 1'b1, 11, 1'b1, RES_DONE, 0);
    // 0x01: one one -> parity 0; 0x00 -> parity 1
    applyStimulus(8'h01, 1'b0, 11, 1'b1, RES_DONE, 0);
    applyStimulus(8'h00, 1'b1, 11, 1'b1, RES_DONE, 0);
    // 0xFF with no acknowledge from the keyboard
    applyStimulus(CMD_RESET, 1'b1, 11, 1'b0, RES_ACKERR, 0);
    // 0xF4 with a keyboard that never clocks
    applyStimulus(CMD_ENABLE, 1'b0, 0, 1'b1, RES_TIMEOUT, 0);

    // Reset in the middle of a frame, after the fifth falling edge.
    bfm_edges = 5;
    bfm_ack   = 1'b1;
    bfm_falls = 0;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    n = 0;
    while (bfm_falls != 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_fifth_edge", bfm_falls, 5);
    repeat (10) @(negedge clk);
    checkOutput("bit4_driven_before_reset", 32'(ps2data_drive_low), 32'd1);
    pulses_before = pulse_count;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_mid_clk_release", 32'(ps2clk_drive_low), 32'd0);
    checkOutput("reset_mid_data_release", 32'(ps2data_drive_low), 32'd0);
    checkOutput("reset_mid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (bfm_active && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    checkOutput("no_pulse_after_reset", pulse_count - pulses_before, 0);

    // 0xFE: seven ones -> parity 0
    applyStimulus(CMD_RESEND, 1'b0, 11, 1'b1, RES_DONE, 0);
    // 0x3C with tx_valid held high and changing data while busy; four ones -> parity 1
    applyStimulus(8'h3C, 1'b1, 11, 1'b1, RES_DONE, 1);

    repeat (100) @(negedge clk);
    checkOutput("results_drained", exp_result_q.size(), 0);
    checkOutput("frames_drained", exp_frame_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
